// File: rtl/mux121_scanner.sv
// mux121_scanner: walks the enabled channels of a downstream 12:1 mux (m121).
// For each enabled channel it drives the select, waits SETTLE cycles for the
// mux output to settle, captures Y, and holds the sample until the consumer
// takes it with READY. A one-cycle DONE pulse marks the end of each pass.
module mux121_scanner #(
    parameter int SETTLE = 1   // select-to-capture wait, 1..15 cycles
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [11:0] MASK,
    input  logic [15:0] Y,
    input  logic        READY,
    output logic        S3,
    output logic        S2,
    output logic        S1,
    output logic        S0,
    output logic [15:0] Q,
    output logic [3:0]  CH,
    output logic        VALID,
    output logic        BUSY,
    output logic        DONE
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SETTLE_W,
        CAP,
        HOLD,
        FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_mask;     // mask latched at START; the pass never sees later changes
    logic [3:0]  r_ptr;      // channel currently being scanned
    logic [3:0]  r_sel;      // registered select to m121
    logic [3:0]  r_cnt;      // settle countdown
    logic [15:0] r_q;
    logic [3:0]  r_ch;
    logic        r_valid;

    logic [3:0]  w_low_ptr;
    logic        w_low_found;
    logic [3:0]  w_nxt_ptr;
    logic        w_nxt_found;

    // Priority search: lowest set bit of the incoming MASK (pass start) and
    // next set bit of the latched mask strictly above the current pointer.
    // Scanning downward lets the last hit be the lowest qualifying bit.
    always_comb begin
        w_low_ptr   = 4'd0;
        w_low_found = 1'b0;
        w_nxt_ptr   = 4'd0;
        w_nxt_found = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (MASK[i]) begin
                w_low_ptr   = 4'(i);
                w_low_found = 1'b1;
            end
            if (r_mask[i] && (4'(i) > r_ptr)) begin
                w_nxt_ptr   = 4'(i);
                w_nxt_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; START is only looked at in IDLE, so it is ignored mid-pass.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (START) w_next = w_low_found ? SEL : FIN;
            SEL:      w_next = SETTLE_W;
            SETTLE_W: if (r_cnt <= 4'd1) w_next = CAP;
            CAP:      w_next = HOLD;
            HOLD:     if (READY) w_next = w_nxt_found ? SEL : FIN;
            FIN:      w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Datapath: mask/pointer bookkeeping, select, settle counter, sample capture.
    // The pointer only ever holds a set mask bit (0..11), so the select can
    // never reach 12..15, and it keeps its last value outside SEL.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mask  <= 12'd0;
            r_ptr   <= 4'd0;
            r_sel   <= 4'd0;
            r_cnt   <= 4'd0;
            r_q     <= 16'd0;
            r_ch    <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_mask <= MASK;
                        r_ptr  <= w_low_ptr;
                    end
                end
                SEL: begin
                    r_sel <= r_ptr;
                    r_cnt <= SETTLE_CNT;
                end
                SETTLE_W: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                CAP: begin
                    r_q     <= Y;
                    r_ch    <= r_ptr;
                    r_valid <= 1'b1;
                end
                HOLD: begin
                    if (READY) begin
                        r_valid <= 1'b0;
                        if (w_nxt_found) r_ptr <= w_nxt_ptr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {S3, S2, S1, S0} = r_sel;
    assign Q     = r_q;
    assign CH    = r_ch;
    assign VALID = r_valid;
    assign BUSY  = (r_state != IDLE);
    assign DONE  = (r_state == FIN);

endmodule

// File: tb/tb_mux121_scanner.sv
// Directed bench for mux121_scanner with SETTLE=1. The m121 mux is modelled
// so that channel n returns n; selects 12..15 return 16'hDEAD.
module tb_mux121_scanner;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [11:0] MASK;
    logic [15:0] Y;
    logic        READY;
    logic        S3, S2, S1, S0;
    logic [15:0] Q;
    logic [3:0]  CH;
    logic        VALID;
    logic        BUSY;
    logic        DONE;
    logic [3:0]  sel;

    int n_tests = 0;
    int n_fail  = 0;

    mux121_scanner #(.SETTLE(1)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MASK(MASK), .Y(Y), .READY(READY),
        .S3(S3), .S2(S2), .S1(S1), .S0(S0), .Q(Q), .CH(CH),
        .VALID(VALID), .BUSY(BUSY), .DONE(DONE)
    );

    assign sel = {S3, S2, S1, S0};
    always_comb Y = (sel < 4'd12) ? {12'd0, sel} : 16'hDEAD;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bounded wait for VALID; ok=0 if it never came.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (VALID === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (DONE === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; MASK = 12'h000; READY = 1'b0;
        #12;
        n_tests++;
        if ({sel, Q, CH, VALID, BUSY, DONE} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: sel=%0h Q=%0h CH=%0h V=%b B=%b D=%b, want all 0",
                     sel, Q, CH, VALID, BUSY, DONE);
        end
        tick();
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if (BUSY !== 1'b0 || DONE !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release_idle: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
            end
        end
    endtask

    // Full pass: sample k selected at c=1+4k, captured at c=3+4k, DONE at c=48.
    task automatic test_full_pass();
        bit v_exp;
        int ndone;
        ndone = 0;
        MASK = 12'hFFF; READY = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        MASK = 12'h000;   // must not affect the pass
        for (int c = 0; c < 56; c++) begin
            v_exp = (c % 4 == 3) && (c < 48);
            n_tests++;
            if (VALID !== v_exp) begin
                n_fail++;
                $display("FAIL full_valid c=%0d: VALID=%b, want %b", c, VALID, v_exp);
            end
            if (c % 4 == 1 && c < 48) begin
                n_tests++;
                if (sel !== 4'(c / 4)) begin
                    n_fail++;
                    $display("FAIL full_sel c=%0d: sel=%0d, want %0d", c, sel, c / 4);
                end
            end
            if (v_exp) begin
                n_tests++;
                if (Q !== 16'(c / 4) || CH !== 4'(c / 4)) begin
                    n_fail++;
                    $display("FAIL full_sample c=%0d: Q=%0h CH=%0d, want %0h %0d",
                             c, Q, CH, c / 4, c / 4);
                end
            end
            n_tests++;
            if (DONE !== (c == 48)) begin
                n_fail++;
                $display("FAIL full_done c=%0d: DONE=%b, want %b", c, DONE, c == 48);
            end
            if (DONE === 1'b1) ndone++;
            tick();
        end
        n_tests++;
        if (ndone != 1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL full_end: done_pulses=%0d BUSY=%b, want 1 0", ndone, BUSY);
        end
    endtask

    task automatic test_sparse();
        logic [3:0]  got_ch [4];
        logic [15:0] got_q  [4];
        int nv, ndone, nbad;
        nv = 0; ndone = 0; nbad = 0;
        MASK = 12'h821; READY = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (sel >= 4'd12) nbad++;
            if (VALID === 1'b1) begin
                if (nv < 4) begin
                    got_ch[nv] = CH;
                    got_q[nv]  = Q;
                end
                nv++;
            end
            if (DONE === 1'b1) ndone++;
            tick();
        end
        n_tests++;
        if (nv != 3 || nbad != 0 || ndone != 1) begin
            n_fail++;
            $display("FAIL sparse_counts: samples=%0d bad_sel=%0d done=%0d, want 3 0 1",
                     nv, nbad, ndone);
        end
        if (nv == 3) begin
            n_tests++;
            if (got_ch[0] !== 4'd0 || got_ch[1] !== 4'd5 || got_ch[2] !== 4'd11 ||
                got_q[0] !== 16'd0 || got_q[1] !== 16'd5 || got_q[2] !== 16'd11) begin
                n_fail++;
                $display("FAIL sparse_order: CH=%0d,%0d,%0d Q=%0h,%0h,%0h, want 0,5,11",
                         got_ch[0], got_ch[1], got_ch[2], got_q[0], got_q[1], got_q[2]);
            end
        end
    endtask

    task automatic test_empty();
        MASK = 12'h000; READY = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        n_tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b1 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_fin: DONE=%b BUSY=%b VALID=%b, want 1 1 0", DONE, BUSY, VALID);
        end
        tick();
        n_tests++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_idle: DONE=%b BUSY=%b VALID=%b, want 0 0 0", DONE, BUSY, VALID);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        MASK = 12'h018; READY = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        wait_valid(ok);
        n_tests++;
        if (!ok || CH !== 4'd3 || Q !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_first: seen=%b CH=%0d Q=%0h, want 1 3 3", ok, CH, Q);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if (VALID !== 1'b1 || CH !== 4'd3 || Q !== 16'd3 || sel !== 4'd3) begin
                n_fail++;
                $display("FAIL bp_stall c=%0d: VALID=%b CH=%0d Q=%0h sel=%0d, want 1 3 3 3",
                         c, VALID, CH, Q, sel);
            end
        end
        READY = 1'b1;
        tick();
        n_tests++;
        if (VALID !== 1'b0 || CH !== 4'd3 || Q !== 16'd3) begin
            n_fail++;
            $display("FAIL bp_release: VALID=%b CH=%0d Q=%0h, want 0 3 3", VALID, CH, Q);
        end
        wait_valid(ok);
        n_tests++;
        if (!ok || CH !== 4'd4 || Q !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_next: seen=%b CH=%0d Q=%0h, want 1 4 4", ok, CH, Q);
        end
        wait_done(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_done: DONE never seen, want 1");
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int ndone;
        ndone = 0;
        MASK = 12'h030; READY = 1'b1; START = 1'b1;
        tick();                 // SEL for CH4
        START = 1'b0;
        tick();                 // SETTLE_W, select now 4
        n_tests++;
        if (sel !== 4'd4 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: sel=%0d BUSY=%b, want 4 1", sel, BUSY);
        end
        #2 RST = 1'b1;
        #1;
        n_tests++;
        if ({sel, Q, CH, VALID, BUSY, DONE} !== 27'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: sel=%0h Q=%0h CH=%0h V=%b B=%b D=%b, want all 0",
                     sel, Q, CH, VALID, BUSY, DONE);
        end
        tick();
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (DONE === 1'b1) ndone++;
            n_tests++;
            if (BUSY !== 1'b0 || VALID !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_idle c=%0d: BUSY=%b VALID=%b, want 0 0", c, BUSY, VALID);
            end
        end
        n_tests++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL rst_mid_nodone: done_pulses=%0d, want 0", ndone);
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_valid(ok);
        n_tests++;
        if (!ok || CH !== 4'd4 || Q !== 16'd4) begin
            n_fail++;
            $display("FAIL rst_mid_restart: seen=%b CH=%0d Q=%0h, want 1 4 4", ok, CH, Q);
        end
        wait_done(ok);
        tick();
    endtask

    task automatic test_start_busy();
        logic [3:0] got_ch [4];
        int nv, ndone;
        nv = 0; ndone = 0;
        MASK = 12'h00C; READY = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        for (int c = 0; c < 40; c++) begin
            START = (c == 2 || c == 3);
            MASK  = (c >= 2) ? 12'hFFF : 12'h00C;
            if (VALID === 1'b1) begin
                if (nv < 4) got_ch[nv] = CH;
                nv++;
            end
            if (DONE === 1'b1) ndone++;
            tick();
        end
        START = 1'b0;
        n_tests++;
        if (nv != 2 || ndone != 1 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_counts: samples=%0d done=%0d BUSY=%b, want 2 1 0",
                     nv, ndone, BUSY);
        end
        if (nv == 2) begin
            n_tests++;
            if (got_ch[0] !== 4'd2 || got_ch[1] !== 4'd3) begin
                n_fail++;
                $display("FAIL busy_order: CH=%0d,%0d, want 2,3", got_ch[0], got_ch[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_sparse();
        test_empty();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
